// File: rtl/rr_fifo_arbiter.sv
// ---------------------------------------------------------------------------
// rr_fifo_arbiter
//
// Round-robin arbiter that merges num_req_p valid/ready requester streams into
// a single stream feeding a downstream FIFO. A grant holds one owner for up to
// burst_p beats. The grant ends early if the owner drops valid. Every release
// is followed by exactly one idle (bubble) cycle before the next grant. The
// search for the next owner starts one past the last owner.
//
// Ports
//   clk_i        in   clock, rising-edge
//   reset_n_i    in   asynchronous active-low reset
//   req_valid_i  in   [num_req_p]            per-requester valid
//   req_data_i   in   [num_req_p][width_p]   per-requester data
//   req_ready_o  out  [num_req_p]            per-requester ready (at most one set)
//   valid_o      out  valid toward downstream FIFO
//   data_o       out  [width_p] data toward downstream FIFO
//   id_o         out  [clog2(num_req_p)] index of requester sourcing data_o
//   ready_i      in   downstream FIFO ready (not full)
// ---------------------------------------------------------------------------
module rr_fifo_arbiter #(
    parameter int num_req_p = 4,
    parameter int width_p   = 8,
    parameter int burst_p   = 4
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p-1:0]                req_valid_i,
    input  logic [num_req_p-1:0][width_p-1:0]   req_data_i,
    output logic [num_req_p-1:0]                req_ready_o,
    output logic                                valid_o,
    output logic [width_p-1:0]                  data_o,
    output logic [$clog2(num_req_p)-1:0]        id_o,
    input  logic                                ready_i
);

    localparam int IW = $clog2(num_req_p);
    localparam int CW = $clog2(burst_p) + 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(burst_p - 1);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   owner_reg;
    logic [IW-1:0]   rr_ptr_reg;
    logic [CW-1:0]   beat_cnt_reg;

    // Request vector rotated so that bit 0 is the requester at rr_ptr. The
    // index sum is IW bits wide, so it wraps modulo num_req_p for free
    // (num_req_p is a power of two).
    logic [num_req_p-1:0] rot_valid;

    genvar gi;
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_rot
            assign rot_valid[gi] = req_valid_i[rr_ptr_reg + IW'(gi)];
        end
    endgenerate

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    logic [IW-1:0] sel_offset;
    logic          sel_found;
    logic [IW-1:0] sel_idx;

    always_comb begin
        sel_offset = '0;
        sel_found  = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!sel_found && rot_valid[i]) begin
                sel_offset = IW'(i);
                sel_found  = 1'b1;
            end
        end
    end

    assign sel_idx = rr_ptr_reg + sel_offset;

    // Beat and release decisions for the current owner.
    logic busy;
    logic owner_valid;
    logic beat_xfer;
    logic last_beat;
    logic release_now;

    assign busy        = (state_reg == ST_BUSY);
    assign owner_valid = req_valid_i[owner_reg];
    assign beat_xfer   = busy && owner_valid && ready_i;
    assign last_beat   = (beat_cnt_reg == BEAT_LAST);
    // An owner that drops valid gives up the grant immediately, without a
    // transfer in that cycle.
    assign release_now = busy && (!owner_valid || (beat_xfer && last_beat));

    // Outputs are a combinational mux of the owner's stream while busy. In
    // idle, and therefore also during reset, they are all driven to zero.
    assign valid_o = busy && owner_valid;
    assign data_o  = busy ? req_data_i[owner_reg] : '0;
    assign id_o    = busy ? owner_reg : '0;

    // Only the owner sees the downstream ready, so req_ready_o is one-hot or zero.
    generate
        for (gi = 0; gi < num_req_p; gi++) begin : g_ready
            assign req_ready_o[gi] = busy && (owner_reg == IW'(gi)) && ready_i;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_found) begin
                        owner_reg    <= sel_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (release_now) begin
                        // The next search starts just past the releasing
                        // owner. The IDLE cycle that follows is the bubble.
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= owner_reg + IW'(1);
                    end else if (beat_xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
